regfile_wb: RTL
===============

Name: regfile_wb

Overview:
- Y86-64 architectural register file. It is the consumer of the writeback-stage outputs: dstE/valE, dstM/valM, icode and stat.
- Commits results on the clock edge, serves the two decode-stage read ports with same-cycle write bypass, tracks halt, and counts retired instructions.
- Sits between the writeback pipeline register and the decode stage.

Parameters:
- RSP_INIT, 64'h0, reset value of register 4 (%rsp).
- BYPASS, 1, when 1 the read ports forward same-cycle writes; when 0 they read the array only.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- wb_stat_i  in  4  stat from writeback stage
- wb_icode_i  in  4  icode from writeback stage
- wb_dstE_i  in  4  E-port destination; 4'hF = RNONE
- wb_valE_i  in  64  E-port data
- wb_dstM_i  in  4  M-port destination; 4'hF = RNONE
- wb_valM_i  in  64  M-port data
- srcA_i  in  4  decode read address A
- srcB_i  in  4  decode read address B
- valA_o  out  64  read data A
- valB_o  out  64  read data B
- dbg_sel_i  in  4  debug read address
- dbg_val_o  out  64  debug read data, array only, no bypass
- halted_o  out  1  sticky halt flag
- retired_o  out  64  retired-instruction count

Behaviour:
- Storage: 15 x 64-bit registers, indices 0..14. Index 15 (RNONE) is never stored.
- Reset (rst_n_i low, asynchronous):
  - all registers 0, except reg 4 = RSP_INIT
  - halted_o = 0, retired_o = 0
  - read outputs reflect the reset array immediately
- Commit enable: commit = (wb_stat_i == STAT_OK) && !halted_o. STAT_BUBBLE, STAT_STALL and STAT_RESET never write and never count.
- Writes on posedge clk_i when commit is high:
  - E port writes if wb_dstE_i != RNONE
  - M port writes if wb_dstM_i != RNONE
  - wb_dstE_i == wb_dstM_i != RNONE: M wins (popq %rsp semantics)
- Reads are combinational:
  - src == RNONE -> 64'h0
  - BYPASS=1 and commit and src == wb_dstM_i -> wb_valM_i
  - else BYPASS=1 and commit and src == wb_dstE_i -> wb_valE_i
  - else array value
- Read latency: a write is visible the same cycle via bypass, or the next cycle via the array.
- Halt: on posedge with commit and wb_icode_i == IHALT (4'h0), halted_o <= 1. The halt instruction itself counts as retired. After that, no writes and no counting until reset.
- retired_o: +1 on each posedge with commit, 64-bit wrap from all-ones to 0.
- Reset asserted mid-operation: state clears immediately. The first edge after release samples normally.
- X handling: wb_val*_i are don't-care when the matching dst is RNONE or commit is 0.

Decomposition:
- Shared package/define.v holds:
  - STAT_OK, STAT_BUBBLE, STAT_STALL, STAT_RESET
  - RNONE = 4'hF, RRSP = 4'h4, IHALT = 4'h0
- No sub-module. Bypass muxing is two identical always_comb blocks, or a function in the package.

Test Plan:
1. Reset with RSP_INIT=64'h1000 -> dbg reg4 = 64'h1000, all other regs 0, retired_o = 0, halted_o = 0.
2. stat OK, dstE=2 valE=64'hA, dstM=RNONE, srcA=2 in the same cycle -> valA_o = 64'hA combinationally; next cycle dbg reg2 = 64'hA, retired_o = 1.
3. stat OK, dstE=4 valE=64'h10, dstM=4 valM=64'h20 -> reg4 = 64'h20; in-cycle srcB=4 gives 64'h20.
4. stat BUBBLE (then STALL), dstE=3 valE=64'h5 -> reg3 unchanged, retired_o unchanged, srcA=3 returns the old value.
5. stat OK, icode=IHALT -> halted_o = 1, retired_o +1; a following OK write dstE=1 valE=64'h7 is ignored and the count stays the same.
6. Assert rst_n_i low mid-cycle after writes -> all registers and the counter clear with no clock edge; srcA=RNONE returns 0 throughout.

Source files
------------

// File: rtl/regfile_wb_pkg.sv
// Shared constants and the read-port bypass helper for the Y86-64 register file.
package regfile_wb_pkg;

    // Writeback-stage status codes.
    localparam logic [3:0] STAT_RESET  = 4'h0;
    localparam logic [3:0] STAT_OK     = 4'h1;
    localparam logic [3:0] STAT_BUBBLE = 4'h2;
    localparam logic [3:0] STAT_STALL  = 4'h3;

    // Register and instruction encodings.
    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;
    localparam logic [3:0] IHALT = 4'h0;

    localparam int unsigned NumRegs = 15;

    // One decode read port: M has priority over E, so a popq %rsp result forwards correctly.
    function automatic logic [63:0] read_port(
        input logic [3:0]  src,
        input logic        bypass_en,
        input logic [3:0]  dst_e,
        input logic [63:0] val_e,
        input logic [3:0]  dst_m,
        input logic [63:0] val_m,
        input logic [63:0] arr_val
    );
        logic [63:0] res;
        if (src == RNONE) begin
            res = 64'h0;
        end else if (bypass_en && (src == dst_m)) begin
            res = val_m;
        end else if (bypass_en && (src == dst_e)) begin
            res = val_e;
        end else begin
            res = arr_val;
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_wb.sv
// Y86-64 architectural register file fed by the writeback stage.
// Commits E/M results, serves two bypassed decode read ports plus an array-only
// debug port, holds a sticky halt flag and counts retired instructions.
module regfile_wb
    import regfile_wb_pkg::*;
#(
    parameter logic [63:0] RSP_INIT = 64'h0,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [3:0]  wb_stat_i,
    input  logic [3:0]  wb_icode_i,
    input  logic [3:0]  wb_dstE_i,
    input  logic [63:0] wb_valE_i,
    input  logic [3:0]  wb_dstM_i,
    input  logic [63:0] wb_valM_i,
    input  logic [3:0]  srcA_i,
    input  logic [3:0]  srcB_i,
    output logic [63:0] valA_o,
    output logic [63:0] valB_o,
    input  logic [3:0]  dbg_sel_i,
    output logic [63:0] dbg_val_o,
    output logic        halted_o,
    output logic [63:0] retired_o
);

    logic [63:0] regs_q [NumRegs];
    logic [63:0] regs_d [NumRegs];
    logic        halted_q, halted_d;
    logic [63:0] retired_q, retired_d;
    logic        commit;
    logic [63:0] arr_a, arr_b;

    assign commit    = (wb_stat_i == STAT_OK) && !halted_q;
    assign halted_o  = halted_q;
    assign retired_o = retired_q;

    // Next-state: E written first so M overwrites it on a shared destination.
    always_comb begin
        for (int i = 0; i < NumRegs; i++) begin
            regs_d[i] = regs_q[i];
        end
        halted_d  = halted_q;
        retired_d = retired_q;
        if (commit) begin
            if (wb_dstE_i != RNONE) begin
                regs_d[wb_dstE_i] = wb_valE_i;
            end
            if (wb_dstM_i != RNONE) begin
                regs_d[wb_dstM_i] = wb_valM_i;
            end
            if (wb_icode_i == IHALT) begin
                halted_d = 1'b1;
            end
            retired_d = retired_q + 64'd1;
        end
    end

    // State registers with asynchronous clear; %rsp comes up at RSP_INIT.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= (i == int'(RRSP)) ? RSP_INIT : 64'h0;
            end
            halted_q  <= 1'b0;
            retired_q <= 64'h0;
        end else begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= regs_d[i];
            end
            halted_q  <= halted_d;
            retired_q <= retired_d;
        end
    end

    // Array lookups; RNONE never indexes the 15-entry array.
    always_comb begin
        arr_a     = 64'h0;
        arr_b     = 64'h0;
        dbg_val_o = 64'h0;
        if (srcA_i != RNONE) begin
            arr_a = regs_q[srcA_i];
        end
        if (srcB_i != RNONE) begin
            arr_b = regs_q[srcB_i];
        end
        if (dbg_sel_i != RNONE) begin
            dbg_val_o = regs_q[dbg_sel_i];
        end
    end

    // Decode read ports with same-cycle forwarding of committing writes.
    always_comb begin
        valA_o = read_port(srcA_i, BYPASS && commit, wb_dstE_i, wb_valE_i,
                           wb_dstM_i, wb_valM_i, arr_a);
        valB_o = read_port(srcB_i, BYPASS && commit, wb_dstE_i, wb_valE_i,
                           wb_dstM_i, wb_valM_i, arr_b);
    end

endmodule
